cordic_divider: RTL and testbench

CORDIC_DIVIDER -- requirements
Module: cordic_divider

---
 rtl/cordic_divider.sv | 169 ++++++++++++++++
 tb/tb_cordic_divider.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cordic_divider : signed fixed-point divider (normalise, linear-vectoring CORDIC, rescale)
// Revision 1.0
// ----------------------------------------------------------------------------
module cordic_divider #(
  parameter int WORD_LENGTH       = 18,
  parameter int FRAC_LENGTH       = 11,
  parameter int NUM_OF_ITERATIONS = 14
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] Numerator,
  input  logic [WORD_LENGTH-1:0] Denominator,
  output logic [WORD_LENGTH-1:0] Quotient,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   div_by_zero,
  output logic                   overflow
);

  localparam int W   = WORD_LENGTH;
  localparam int MW  = WORD_LENGTH + 1;
  localparam int DW  = WORD_LENGTH + 4;
  localparam int ZF  = NUM_OF_ITERATIONS + 2;
  localparam int ZW  = ZF + 1;
  localparam int EW  = $clog2(3 * WORD_LENGTH) + 2;
  localparam int CW  = $clog2(NUM_OF_ITERATIONS + 1);
  localparam int OFF = WORD_LENGTH + ZF;
  localparam int XW  = ZW + 2 * WORD_LENGTH + FRAC_LENGTH;
  localparam int QW  = XW - OFF;

  typedef enum logic [2:0] {IDLE, NORM, ITER, SCALE, DONE} state_t;

  state_t                state, state_next;
  logic                  sign, num_neg, num_zero, den_zero;
  logic [MW-1:0]         mag_n, mag_d, abs_n, abs_d;
  logic signed [EW-1:0]  exp_n, exp_d;
  logic signed [DW-1:0]  y, x, x_sh;
  logic [ZW-1:0]         z, z_inc;
  logic [CW-1:0]         iter;
  logic                  norm_n, norm_d, last_iter;
  logic [EW-1:0]         shamt;
  logic [XW-1:0]         z_wide, z_round;
  logic [QW-1:0]         q_mag, limit;
  logic                  sat;
  logic [W-1:0]          q_abs, q_scaled;

  // Magnitudes carry one extra bit so -2^(W-1) negates exactly.
  assign abs_n = Numerator[W-1]   ? (MW'(0) - {1'b1, Numerator})   : {1'b0, Numerator};
  assign abs_d = Denominator[W-1] ? (MW'(0) - {1'b1, Denominator}) : {1'b0, Denominator};

  // Mantissa register holds W fraction bits; normalised means value in [0.5, 1.0).
  assign norm_n    = (mag_n[MW-1:MW-2] == 2'b01);
  assign norm_d    = (mag_d[MW-1:MW-2] == 2'b01);
  assign last_iter = (iter == CW'(NUM_OF_ITERATIONS - 1));
  assign x_sh      = x >>> iter;
  assign z_inc     = (ZW'(1) << ZF) >> iter;

  // Shift is offset by OFF so it is never negative; rounding happens on the final drop of OFF bits.
  assign shamt    = exp_n - exp_d + EW'(WORD_LENGTH + FRAC_LENGTH);
  assign z_wide   = XW'(z) << shamt;
  assign z_round  = z_wide + (XW'(1) << (OFF - 1));
  assign q_mag    = QW'(z_round >> OFF);
  assign limit    = sign ? (QW'(1) << (W - 1)) : ((QW'(1) << (W - 1)) - QW'(1));
  assign sat      = (q_mag > limit);
  assign q_abs    = sat ? limit[W-1:0] : q_mag[W-1:0];
  assign q_scaled = sign ? (W'(0) - q_abs) : q_abs;

  assign out_valid = (state == DONE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_next = NORM;
      NORM:    if (den_zero || num_zero) state_next = DONE;
               else if (norm_n && norm_d) state_next = ITER;
      ITER:    if (last_iter) state_next = SCALE;
      SCALE:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sign        <= 1'b0;
      num_neg     <= 1'b0;
      num_zero    <= 1'b0;
      den_zero    <= 1'b0;
      mag_n       <= '0;
      mag_d       <= '0;
      exp_n       <= '0;
      exp_d       <= '0;
      y           <= '0;
      x           <= '0;
      z           <= '0;
      iter        <= '0;
      Quotient    <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          sign     <= Numerator[W-1] ^ Denominator[W-1];
          num_neg  <= Numerator[W-1];
          num_zero <= (Numerator == '0);
          den_zero <= (Denominator == '0);
          mag_n    <= abs_n;
          mag_d    <= abs_d;
          exp_n    <= EW'(WORD_LENGTH - FRAC_LENGTH);
          exp_d    <= EW'(WORD_LENGTH - FRAC_LENGTH);
        end
        NORM: if (den_zero) begin
          Quotient    <= num_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          div_by_zero <= 1'b1;
          overflow    <= 1'b1;
        end else if (num_zero) begin
          Quotient    <= '0;
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
        end else begin
          if (!norm_n) begin
            mag_n <= mag_n[MW-1] ? (mag_n >> 1) : (mag_n << 1);
            exp_n <= mag_n[MW-1] ? (exp_n + EW'(1)) : (exp_n - EW'(1));
          end
          if (!norm_d) begin
            mag_d <= mag_d[MW-1] ? (mag_d >> 1) : (mag_d << 1);
            exp_d <= mag_d[MW-1] ? (exp_d + EW'(1)) : (exp_d - EW'(1));
          end
          y    <= {1'b0, mag_n, 2'b00};
          x    <= {1'b0, mag_d, 2'b00};
          z    <= '0;
          iter <= '0;
        end
        ITER: begin
          iter <= iter + CW'(1);
          if (!y[DW-1]) begin
            y <= y - x_sh;
            z <= z + z_inc;
          end else begin
            y <= y + x_sh;
            z <= z - z_inc;
          end
        end
        SCALE: begin
          Quotient    <= q_scaled;
          overflow    <= sat;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_divider.sv
`default_nettype none
`timescale 1ns/1ps
// tb_cordic_divider : directed checks of the CORDIC divider at default parameters (Q6.11, 18 bit).
module tb_cordic_divider;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [17:0] Numerator = '0;
  logic signed [17:0] Denominator = '0;
  logic signed [17:0] Quotient;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               div_by_zero;
  logic               overflow;

  int n_cmp = 0;
  int n_bad = 0;

  cordic_divider dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .Numerator(Numerator), .Denominator(Denominator), .Quotient(Quotient),
    .out_valid(out_valid), .out_ready(out_ready),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_op(input logic signed [17:0] n, input logic signed [17:0] d, input bit ack,
                        output int q, output logic dz, output logic ov, output int lat, output bit to);
    int guard = 0;
    while (!in_ready && guard < 60) begin step(); guard++; end
    Numerator = n; Denominator = d; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin step(); lat++; end
    to = !out_valid;
    q = Quotient; dz = div_by_zero; ov = overflow;
    if (ack) begin out_ready = 1'b1; step(); out_ready = 1'b0; end
  endtask

  task automatic test_reset();
    #1 RST = 1'b0;
    repeat (2) step();
    n_cmp++; if (Quotient !== 18'sd0) begin n_bad++; $display("FAIL rst_quotient: got %0d want 0", Quotient); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL rst_dz: got %b want 0", div_by_zero); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ov: got %b want 0", overflow); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    RST = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int q, lat; logic dz, ov; bit to;
    run_op(18'sd2048, 18'sd4096, 1'b1, q, dz, ov, lat, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %b want 0", to); end
    n_cmp++; if (q > 1025 || q < 1023) begin n_bad++; $display("FAIL basic_q: got %0d want 1024+/-1", q); end
    n_cmp++; if (dz !== 1'b0 || ov !== 1'b0) begin n_bad++; $display("FAIL basic_flags: got dz=%b ov=%b want 0 0", dz, ov); end
    n_cmp++; if (lat !== 23) begin n_bad++; $display("FAIL basic_latency: got %0d want 23", lat); end
  endtask

  task automatic test_negative();
    int q, lat; logic dz, ov; bit to;
    run_op(-18'sd3072, 18'sd1024, 1'b1, q, dz, ov, lat, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL neg_timeout: got %b want 0", to); end
    n_cmp++; if (q > -6142 || q < -6146) begin n_bad++; $display("FAIL neg_q: got %0d want -6144+/-2", q); end
    n_cmp++; if (dz !== 1'b0 || ov !== 1'b0) begin n_bad++; $display("FAIL neg_flags: got dz=%b ov=%b want 0 0", dz, ov); end
    n_cmp++; if (lat !== 24) begin n_bad++; $display("FAIL neg_latency: got %0d want 24", lat); end
    run_op(-18'sd131072, 18'sd4096, 1'b1, q, dz, ov, lat, to);
    n_cmp++; if (q > -65520 || q < -65552) begin n_bad++; $display("FAIL minneg_q: got %0d want -65536+/-16", q); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL minneg_ov: got %b want 0", ov); end
  endtask

  task automatic test_div_zero();
    int q, lat; logic dz, ov; bit to;
    run_op(18'sd100, 18'sd0, 1'b1, q, dz, ov, lat, to);
    n_cmp++; if (q !== 131071) begin n_bad++; $display("FAIL dz_pos_q: got %0d want 131071", q); end
    n_cmp++; if (dz !== 1'b1 || ov !== 1'b1) begin n_bad++; $display("FAIL dz_pos_flags: got dz=%b ov=%b want 1 1", dz, ov); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL dz_latency: got %0d want 2", lat); end
    run_op(-18'sd5, 18'sd0, 1'b1, q, dz, ov, lat, to);
    n_cmp++; if (q !== -131072) begin n_bad++; $display("FAIL dz_neg_q: got %0d want -131072", q); end
    n_cmp++; if (dz !== 1'b1 || ov !== 1'b1) begin n_bad++; $display("FAIL dz_neg_flags: got dz=%b ov=%b want 1 1", dz, ov); end
    run_op(18'sd0, 18'sd0, 1'b1, q, dz, ov, lat, to);
    n_cmp++; if (q !== 131071 || dz !== 1'b1) begin n_bad++; $display("FAIL dz_zero_q: got %0d dz=%b want 131071 1", q, dz); end
  endtask

  task automatic test_num_zero();
    int q, lat; logic dz, ov; bit to;
    run_op(18'sd0, 18'sd77, 1'b1, q, dz, ov, lat, to);
    n_cmp++; if (q !== 0) begin n_bad++; $display("FAIL nz_q: got %0d want 0", q); end
    n_cmp++; if (dz !== 1'b0 || ov !== 1'b0) begin n_bad++; $display("FAIL nz_flags: got dz=%b ov=%b want 0 0", dz, ov); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL nz_latency: got %0d want 2", lat); end
  endtask

  task automatic test_overflow();
    int q, lat; logic dz, ov; bit to;
    run_op(18'sd120000, 18'sd16, 1'b1, q, dz, ov, lat, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL ovf_timeout: got %b want 0", to); end
    n_cmp++; if (q !== 131071) begin n_bad++; $display("FAIL ovf_q: got %0d want 131071", q); end
    n_cmp++; if (ov !== 1'b1 || dz !== 1'b0) begin n_bad++; $display("FAIL ovf_flags: got ov=%b dz=%b want 1 0", ov, dz); end
    run_op(-18'sd131072, -18'sd2048, 1'b1, q, dz, ov, lat, to);
    n_cmp++; if (q !== 131071 || ov !== 1'b1) begin n_bad++; $display("FAIL ovf_minneg: got %0d ov=%b want 131071 1", q, ov); end
  endtask

  task automatic test_back_pressure();
    int q, q0, lat; logic dz, ov; bit to;
    run_op(18'sd2048, 18'sd4096, 1'b0, q0, dz, ov, lat, to);
    n_cmp++; if (q0 > 1025 || q0 < 1023) begin n_bad++; $display("FAIL bp_q: got %0d want 1024+/-1", q0); end
    for (int i = 0; i < 5; i++) begin
      Numerator = 18'sd555; Denominator = 18'sd3; in_valid = 1'b1;
      step();
      q = Quotient;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_%0d: got %b want 1", i, out_valid); end
      n_cmp++; if (q !== q0) begin n_bad++; $display("FAIL bp_stable_%0d: got %0d want %0d", i, q, q0); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_%0d: got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    repeat (3) step();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ignored: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_iter();
    int q, lat; logic dz, ov; bit to;
    Numerator = 18'sd2048; Denominator = 18'sd2048; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stray_ready: got valid=%b want 0", out_valid); end
    repeat (9) step();
    RST = 1'b0;
    #1;
    n_cmp++; if (Quotient !== 18'sd0) begin n_bad++; $display("FAIL mid_rst_q: got %0d want 0", Quotient); end
    n_cmp++; if (out_valid !== 1'b0 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_flags: got valid=%b dz=%b ov=%b want 0 0 0", out_valid, div_by_zero, overflow);
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
    repeat (2) step();
    RST = 1'b1;
    step();
    run_op(18'sd2048, 18'sd2048, 1'b1, q, dz, ov, lat, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL mid_after_timeout: got %b want 0", to); end
    n_cmp++; if (q > 2049 || q < 2047) begin n_bad++; $display("FAIL mid_after_q: got %0d want 2048+/-1", q); end
    n_cmp++; if (dz !== 1'b0 || ov !== 1'b0) begin n_bad++; $display("FAIL mid_after_flags: got dz=%b ov=%b want 0 0", dz, ov); end
    n_cmp++; if (lat !== 23) begin n_bad++; $display("FAIL mid_after_latency: got %0d want 23", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_div_zero();
    test_num_zero();
    test_overflow();
    test_back_pressure();
    test_reset_mid_iter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
